// File: rtl/age_issue_queue_pkg.sv
// Shared defaults and the issue-queue entry record for the age-ordered issue queue.
package iq_pkg;

    localparam int IQ_DEPTH      = 16;
    localparam int IQ_TAG_W      = 6;
    localparam int IQ_PAYLOAD_W  = 32;
    localparam int IQ_WAKE_PORTS = 2;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_TAG_W-1:0]     src1;
        logic [IQ_TAG_W-1:0]     src2;
        logic                    src1_rdy;
        logic                    src2_rdy;
        logic [IQ_TAG_W-1:0]     dest;
    } iq_entry_t;

endpackage

// File: rtl/age_issue_queue_if.sv
// Enqueue, wakeup and issue signals of the issue queue.
// The slave modport is the queue side.
interface age_issue_queue_if import iq_pkg::*; #(
    parameter int PAYLOAD_W  = IQ_PAYLOAD_W,
    parameter int TAG_W      = IQ_TAG_W,
    parameter int WAKE_PORTS = IQ_WAKE_PORTS
);
    logic                        enq_valid;
    logic                        enq_ready;
    logic [PAYLOAD_W-1:0]        enq_payload;
    logic [TAG_W-1:0]            enq_src1;
    logic [TAG_W-1:0]            enq_src2;
    logic                        enq_src1_rdy;
    logic                        enq_src2_rdy;
    logic [TAG_W-1:0]            enq_dest;
    logic [WAKE_PORTS-1:0]       wake_valid;
    logic [WAKE_PORTS*TAG_W-1:0] wake_tag;
    logic                        iss_valid;
    logic                        iss_ready;
    logic [PAYLOAD_W-1:0]        iss_payload;
    logic [TAG_W-1:0]            iss_dest;

    modport master (
        output enq_valid, enq_payload, enq_src1, enq_src2, enq_src1_rdy, enq_src2_rdy,
               enq_dest, wake_valid, wake_tag, iss_ready,
        input  enq_ready, iss_valid, iss_payload, iss_dest
    );

    modport slave (
        input  enq_valid, enq_payload, enq_src1, enq_src2, enq_src1_rdy, enq_src2_rdy,
               enq_dest, wake_valid, wake_tag, iss_ready,
        output enq_ready, iss_valid, iss_payload, iss_dest
    );
endinterface

// File: rtl/age_issue_queue_age_select.sv
// Oldest-first picker: grants the candidate that no other candidate is older than.
module iq_age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            cand,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        grant_valid
);
    logic [DEPTH-1:0] blocked;

    // age[i][j] set means entry i is older than entry j
    always_comb begin
        blocked = '0;
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i != j && cand[i] && age[i][j]) begin
                    blocked[j] = 1'b1;
                end
            end
        end
    end

    assign grant       = cand & ~blocked;
    assign grant_valid = |cand;
endmodule

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue with multi-port wakeup, lowest-free-slot allocation and age-matrix select.
// Optional IQ_WAKE_BYPASS_EN: same-cycle wakeups also mark the entry being enqueued ready.
module age_issue_queue import iq_pkg::*; #(
    parameter  int DEPTH      = IQ_DEPTH,
    parameter  int TAG_W      = IQ_TAG_W,
    parameter  int PAYLOAD_W  = IQ_PAYLOAD_W,
    parameter  int WAKE_PORTS = IQ_WAKE_PORTS,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    age_issue_queue_if.slave  bus,
    output logic [CNT_W-1:0]  count
);
    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]     src1;
        logic [TAG_W-1:0]     src2;
        logic                 src1_rdy;
        logic                 src2_rdy;
        logic [TAG_W-1:0]     dest;
    } entry_t;

    entry_t                      ent_q [DEPTH];
    entry_t                      ent_d [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] free_oh;
    logic             free_found;
    logic             grant_valid;
    logic [CNT_W-1:0] count_w;
    logic             enq_ready_w;
    logic             iss_valid_w;
    logic             enq_fire;
    logic             iss_fire;
    logic             byp1, byp2;

    function automatic logic wake_hit(
        input logic [TAG_W-1:0]            tag,
        input logic [WAKE_PORTS-1:0]       wv,
        input logic [WAKE_PORTS*TAG_W-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WAKE_PORTS; k++) begin
            if (wv[k] && wt[k*TAG_W +: TAG_W] == tag) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        valid_vec = '0;
        cand      = '0;
        count_w   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            cand[i]      = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
            count_w      = count_w + CNT_W'(ent_q[i].valid);
        end
    end

    always_comb begin
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_vec[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    iq_age_select #(.DEPTH(DEPTH)) u_age_select (
        .cand        (cand),
        .age         (age_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign enq_ready_w = (count_w != CNT_W'(DEPTH));
    assign iss_valid_w = grant_valid && !flush;
    assign enq_fire    = bus.enq_valid && enq_ready_w && !flush;
    assign iss_fire    = iss_valid_w && bus.iss_ready;

`ifdef IQ_WAKE_BYPASS_EN
    assign byp1 = wake_hit(bus.enq_src1, bus.wake_valid, bus.wake_tag);
    assign byp2 = wake_hit(bus.enq_src2, bus.wake_valid, bus.wake_tag);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Output mux forced to zero while flushing so payload/dest read 0 whenever iss_valid is low
    always_comb begin
        bus.iss_payload = '0;
        bus.iss_dest    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i] && !flush) begin
                bus.iss_payload = bus.iss_payload | ent_q[i].payload;
                bus.iss_dest    = bus.iss_dest | ent_q[i].dest;
            end
        end
    end

    assign bus.iss_valid = iss_valid_w;
    assign bus.enq_ready = enq_ready_w;
    assign count         = count_w;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        age_d = age_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid) begin
                    if (wake_hit(ent_q[i].src1, bus.wake_valid, bus.wake_tag)) ent_d[i].src1_rdy = 1'b1;
                    if (wake_hit(ent_q[i].src2, bus.wake_valid, bus.wake_tag)) ent_d[i].src2_rdy = 1'b1;
                end
                if (iss_fire && grant[i]) begin
                    ent_d[i].valid = 1'b0;
                end
            end
            // New entry is younger than everything currently valid
            if (enq_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (free_oh[i]) begin
                        ent_d[i].valid    = 1'b1;
                        ent_d[i].payload  = bus.enq_payload;
                        ent_d[i].src1     = bus.enq_src1;
                        ent_d[i].src2     = bus.enq_src2;
                        ent_d[i].src1_rdy = bus.enq_src1_rdy || byp1;
                        ent_d[i].src2_rdy = bus.enq_src2_rdy || byp2;
                        ent_d[i].dest     = bus.enq_dest;
                        age_d[i]          = '0;
                        for (int j = 0; j < DEPTH; j++) begin
                            age_d[j][i] = valid_vec[j];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            age_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            age_q <= age_d;
        end
    end
endmodule

// File: tb/tb_age_issue_queue.sv
// Scenario bench for age_issue_queue; issued instructions are checked against an in-order scoreboard.
module tb_age_issue_queue;
    import iq_pkg::*;

    localparam int DEPTH      = 16;
    localparam int TAG_W      = 6;
    localparam int PAYLOAD_W  = 32;
    localparam int WAKE_PORTS = 2;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] count;

    int        checks = 0;
    int        errors = 0;
    iq_entry_t sb[$];
    iq_entry_t exp_e;

    age_issue_queue_if #(.PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W), .WAKE_PORTS(WAKE_PORTS)) bus ();

    age_issue_queue #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .WAKE_PORTS(WAKE_PORTS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    // Every accepted issue must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.iss_valid && bus.iss_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_issue: unexpected issue payload=%h dest=%0d, none expected", bus.iss_payload, bus.iss_dest);
            end else begin
                exp_e = sb.pop_front();
                if (bus.iss_payload !== exp_e.payload || bus.iss_dest !== exp_e.dest) begin
                    errors++;
                    $display("FAIL sb_issue: got payload=%h dest=%0d want payload=%h dest=%0d",
                             bus.iss_payload, bus.iss_dest, exp_e.payload, exp_e.dest);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.enq_valid  = 1'b0;
        bus.wake_valid = '0;
        flush          = 1'b0;
    endtask

    task automatic drive_enq(input logic [31:0] p, input logic [5:0] s1, input logic [5:0] s2,
                             input logic r1, input logic r2, input logic [5:0] d);
        bus.enq_valid    = 1'b1;
        bus.enq_payload  = p;
        bus.enq_src1     = s1;
        bus.enq_src2     = s2;
        bus.enq_src1_rdy = r1;
        bus.enq_src2_rdy = r2;
        bus.enq_dest     = d;
    endtask

    task automatic wake(input int port, input logic [5:0] tag);
        bus.wake_valid[port]             = 1'b1;
        bus.wake_tag[port*TAG_W +: TAG_W] = tag;
    endtask

    function automatic iq_entry_t mk(input logic [31:0] p, input logic [5:0] d);
        iq_entry_t e;
        e         = '0;
        e.valid   = 1'b1;
        e.payload = p;
        e.dest    = d;
        return e;
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL rst_enq_ready: got %b want 1", bus.enq_ready); end
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid: got %b want 0", bus.iss_valid); end
        checks++; if (bus.iss_payload !== 32'd0 || bus.iss_dest !== 6'd0) begin
            errors++; $display("FAIL rst_iss_data: got %h/%0d want 0/0", bus.iss_payload, bus.iss_dest); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        bus.iss_ready = 1'b1;
        drive_enq(32'hA000_0001, 6'd3, 6'd4, 1'b1, 1'b1, 6'd10);
        sb.push_back(mk(32'hA000_0001, 6'd10));
        tick();
        drive_enq(32'hB000_0002, 6'd5, 6'd6, 1'b1, 1'b1, 6'd11);
        sb.push_back(mk(32'hB000_0002, 6'd11));
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL ord_count1: got %0d want 1", count); end
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'hA000_0001) begin
            errors++; $display("FAIL ord_first: got v=%b p=%h want v=1 p=a0000001", bus.iss_valid, bus.iss_payload); end
        tick();
        idle();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL ord_count2: got %0d want 1", count); end
        checks++; if (bus.iss_payload !== 32'hB000_0002) begin
            errors++; $display("FAIL ord_second: got %h want b0000002", bus.iss_payload); end
        tick();
        checks++; if (count !== 5'd0 || bus.iss_valid !== 1'b0) begin
            errors++; $display("FAIL ord_drain: got count=%0d v=%b want 0/0", count, bus.iss_valid); end
    endtask

    task automatic test_wakeup_order();
        bus.iss_ready = 1'b1;
        drive_enq(32'hA000_0022, 6'd7, 6'd8, 1'b0, 1'b1, 6'd12);
        sb.push_back(mk(32'hB000_0022, 6'd13));
        sb.push_back(mk(32'hA000_0022, 6'd12));
        tick();
        drive_enq(32'hB000_0022, 6'd1, 6'd2, 1'b1, 1'b1, 6'd13);
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wk_not_ready: got %b want 0", bus.iss_valid); end
        tick();
        idle();
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_dest !== 6'd13) begin
            errors++; $display("FAIL wk_young_first: got v=%b d=%0d want v=1 d=13", bus.iss_valid, bus.iss_dest); end
        tick();
        checks++; if (bus.iss_valid !== 1'b0 || count !== 5'd1) begin
            errors++; $display("FAIL wk_waiting: got v=%b count=%0d want 0/1", bus.iss_valid, count); end
        wake(1, 6'd7);
        tick();
        idle();
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'hA000_0022) begin
            errors++; $display("FAIL wk_woken: got v=%b p=%h want v=1 p=a0000022", bus.iss_valid, bus.iss_payload); end
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wk_drain: got %0d want 0", count); end
    endtask

    task automatic test_dual_wake();
        bus.iss_ready = 1'b0;
        drive_enq(32'hC000_0033, 6'd5, 6'd9, 1'b0, 1'b0, 6'd14);
        tick();
        idle();
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL dual_pre: got %b want 0", bus.iss_valid); end
        wake(0, 6'd5);
        wake(1, 6'd9);
        tick();
        idle();
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_dest !== 6'd14) begin
            errors++; $display("FAIL dual_ready: got v=%b d=%0d want v=1 d=14", bus.iss_valid, bus.iss_dest); end
        sb.push_back(mk(32'hC000_0033, 6'd14));
        bus.iss_ready = 1'b1;
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL dual_drain: got %0d want 0", count); end
    endtask

    task automatic test_bypass();
        bus.iss_ready = 1'b1;
        drive_enq(32'hD000_0044, 6'd12, 6'd13, 1'b0, 1'b1, 6'd15);
        wake(0, 6'd12);
        sb.push_back(mk(32'hD000_0044, 6'd15));
        tick();
        idle();
`ifdef IQ_WAKE_BYPASS_EN
        checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL byp_ready: got %b want 1", bus.iss_valid); end
        tick();
`else
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL byp_not_seen: got %b want 0", bus.iss_valid); end
        wake(0, 6'd12);
        tick();
        idle();
        checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL byp_late_wake: got %b want 1", bus.iss_valid); end
        tick();
`endif
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL byp_drain: got %0d want 0", count); end
    endtask

    task automatic test_full();
        bus.iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_enq(32'h100 + i, 6'(16 + i), 6'd50, 1'b0, 1'b1, 6'(i));
            tick();
            checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL full_fill: got %0d want %0d", count, i + 1); end
        end
        idle();
        checks++; if (bus.enq_ready !== 1'b0 || count !== 5'd16) begin
            errors++; $display("FAIL full_state: got rdy=%b count=%0d want 0/16", bus.enq_ready, count); end
        drive_enq(32'hDEAD_BEEF, 6'd1, 6'd1, 1'b1, 1'b1, 6'd63);
        tick();
        idle();
        checks++; if (count !== 5'd16 || bus.iss_valid !== 1'b0) begin
            errors++; $display("FAIL full_reject: got count=%0d v=%b want 16/0", count, bus.iss_valid); end
        sb.push_back(mk(32'h105, 6'd5));
        wake(0, 6'd21);
        bus.iss_ready = 1'b1;
        tick();
        idle();
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h105) begin
            errors++; $display("FAIL full_wake: got v=%b p=%h want v=1 p=105", bus.iss_valid, bus.iss_payload); end
        tick();
        checks++; if (bus.enq_ready !== 1'b1 || count !== 5'd15 || bus.iss_valid !== 1'b0) begin
            errors++; $display("FAIL full_free: got rdy=%b count=%0d v=%b want 1/15/0", bus.enq_ready, count, bus.iss_valid); end
    endtask

    task automatic test_flush();
        bus.iss_ready = 1'b0;
        flush = 1'b1;
        tick();
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL fl_clear_left: got %0d want 0", count); end
        for (int i = 0; i < 5; i++) begin
            drive_enq(32'h200 + i, 6'd1, 6'd2, 1'b1, 1'b1, 6'(20 + i));
            tick();
        end
        idle();
        checks++; if (count !== 5'd5 || bus.iss_valid !== 1'b1) begin
            errors++; $display("FAIL fl_filled: got count=%0d v=%b want 5/1", count, bus.iss_valid); end
        flush = 1'b1;
        bus.iss_ready = 1'b1;
        drive_enq(32'h2FF, 6'd1, 6'd2, 1'b1, 1'b1, 6'd30);
        #1;
        checks++; if (bus.iss_valid !== 1'b0 || bus.iss_payload !== 32'd0) begin
            errors++; $display("FAIL fl_iss_gated: got v=%b p=%h want 0/0", bus.iss_valid, bus.iss_payload); end
        tick();
        idle();
        checks++; if (count !== 5'd0 || bus.enq_ready !== 1'b1 || bus.iss_valid !== 1'b0) begin
            errors++; $display("FAIL fl_after: got count=%0d rdy=%b v=%b want 0/1/0", count, bus.enq_ready, bus.iss_valid); end
    endtask

    task automatic test_reset_mid();
        bus.iss_ready = 1'b0;
        drive_enq(32'h300, 6'd1, 6'd2, 1'b1, 1'b1, 6'd40);
        tick();
        drive_enq(32'h301, 6'd1, 6'd2, 1'b1, 1'b1, 6'd41);
        tick();
        idle();
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL rm_filled: got %0d want 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || bus.iss_valid !== 1'b0 || bus.iss_payload !== 32'd0) begin
            errors++; $display("FAIL rm_async: got count=%0d v=%b p=%h want 0/0/0", count, bus.iss_valid, bus.iss_payload); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.iss_ready    = 1'b0;
        bus.enq_valid    = 1'b0;
        bus.enq_payload  = '0;
        bus.enq_src1     = '0;
        bus.enq_src2     = '0;
        bus.enq_src1_rdy = 1'b0;
        bus.enq_src2_rdy = 1'b0;
        bus.enq_dest     = '0;
        bus.wake_valid   = '0;
        bus.wake_tag     = '0;

        test_reset();
        test_in_order();
        test_wakeup_order();
        test_dual_wake();
        test_bypass();
        test_full();
        test_flush();
        test_reset_mid();

        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/age_issue_queue.md
# age_issue_queue

Parametrised out-of-order issue queue that sits between rename and the execution units. It accepts renamed instructions through a valid/ready handshake and tracks per-source operand readiness. It wakes operands from multiple writeback broadcast ports and issues the oldest fully ready entry through a second valid/ready handshake. It adds lowest-free-slot allocation, an age matrix for oldest-first select, a full/occupancy indication and pipeline flush.

## Interface
Parameters:
- DEPTH, 16: number of entries (2..64).
- TAG_W, 6: physical register tag width.
- PAYLOAD_W, 32: instruction payload width.
- WAKE_PORTS, 2: number of wakeup broadcast ports.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries.
- enq_valid  in  1  enqueue request.
- enq_ready  out  1  queue can accept (not full).
- enq_payload  in  PAYLOAD_W  instruction word.
- enq_src1, enq_src2  in  TAG_W  source physical tags.
- enq_src1_rdy, enq_src2_rdy  in  1  source already available at rename.
- enq_dest  in  TAG_W  destination physical tag.
- wake_valid  in  WAKE_PORTS  per-port wakeup strobe.
- wake_tag  in  WAKE_PORTS*TAG_W  per-port tag, port k at bits [k*TAG_W +: TAG_W].
- iss_valid  out  1  an entry is ready to issue.
- iss_ready  in  1  execution unit accepts.
- iss_payload  out  PAYLOAD_W  payload of selected entry.
- iss_dest  out  TAG_W  dest tag of selected entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Per entry: valid, payload, src1/src2 tags, src1_rdy/src2_rdy, dest. The age matrix holds DEPTH×DEPTH bits, where bit [i][j] means entry i is older than j.
- Enqueue fires on enq_valid && enq_ready. The lowest-index free slot is written with valid=1 and rdy bits from enq_srcN_rdy. The new entry is marked younger than all valid entries: row cleared, column set.
- Wakeup: for every valid entry and every port k with wake_valid[k], srcN_rdy sets when srcN == wake_tag[k]. All ports are evaluated in parallel.
- Select: the candidate set is valid && src1_rdy && src2_rdy. The chosen entry is the candidate with no older candidate. iss_valid = |candidates && !flush.
- Issue fires on iss_valid && iss_ready and clears that entry's valid bit.
- count = popcount(valid); enq_ready = (count != DEPTH).
- Simultaneous enqueue and issue in one cycle: both take effect and count is unchanged. Issue does not free a slot for same-cycle enqueue.
- Flush clears all valid bits. Enqueue and issue are ignored in the flush cycle. Wakeups in the flush cycle are dropped.
- Wakeup matching the dest of the entry issuing in the same cycle is legal and has no effect on it.

## Timing
- Reset, asynchronous: all valid=0, age matrix=0, count=0, enq_ready=1, iss_valid=0. iss_payload and iss_dest are 0 while iss_valid=0.
- iss_valid, iss_payload, iss_dest and enq_ready are combinational from registered state only. There is no path from the enq_* or wake_* inputs.
- Minimum enqueue-to-issue latency is 1 cycle: entry enqueued with both rdy=1 at edge N gives iss_valid high in cycle N+1.
- Wakeup at edge N makes the entry visible as ready in cycle N+1.
- iss_payload and iss_dest stay stable while iss_valid=1 && !iss_ready, unless an older entry becomes ready. In that case the selection may change, because holding is not required.
- Reset asserted mid-operation discards all entries immediately.

## Configuration
- IQ_WAKE_BYPASS_EN defined: a wakeup in the same cycle as an enqueue also sets the enqueuing entry's srcN_rdy when enq_srcN matches any active wake_tag.
- IQ_WAKE_BYPASS_EN undefined: a same-cycle wakeup is not seen by the enqueuing entry. Upstream rename is required to fold that cycle's wakeups into enq_srcN_rdy.

## Structure
- Package iq_pkg: entry struct typedef (valid, payload, src tags, rdy bits, dest), and the DEPTH/TAG_W defaults as localparams.
- Sub-module iq_age_select takes a DEPTH-bit candidate vector and the age matrix. It outputs a one-hot grant and a valid signal. The top level muxes payload and dest from the one-hot grant.

## Test plan
- Enqueue A(src 3,4 rdy=1,1) and then B(rdy=1,1) with iss_ready=1 -> A issues in cycle 1 and B in cycle 2, in order. count goes 1,1,0.
- Enqueue A(src1=7, rdy=0) and then B(rdy=1,1) -> B issues first. wake_valid[1]=1, wake_tag=7 -> A issues the following cycle.
- Fill 16 entries with rdy=0 -> enq_ready=0 and count=16, and a 17th enq_valid is not accepted. Wake one entry -> it issues and enq_ready=1 the next cycle.
- Two ports wake tags 5 and 9 in the same cycle for entry (src1=5, src2=9) -> iss_valid=1 next cycle.
- With IQ_WAKE_BYPASS_EN, enqueue (src1=12 rdy=0, src2 rdy=1) while wake_tag[0]=12 -> iss_valid next cycle. Without the macro -> entry stays not ready.
- 5 entries valid, assert flush with iss_ready=1 -> iss_valid=0 in the flush cycle, count=0 and enq_ready=1 in the next cycle.
